// File: rtl/writeback_arbiter_pkg.sv
// Shared definitions for the writeback arbiter slice.
// Provides the register-address width, the register count, the hardwired
// zero register and the grant encoding used by the round-robin pointer.
package writeback_arbiter_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned NUM_REGS   = 32;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

  // Port currently holding priority on a tie.
  typedef enum logic {
    GRANT_ALU = 1'b0,
    GRANT_LSU = 1'b1
  } grant_e;

endpackage

// File: rtl/wb_scoreboard.sv
// Pending-write scoreboard for long-latency destinations.
// Holds one pending bit per architectural register (bit 0 is always 0).
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   issue_valid/issue_rd  reservation request and its destination
//   issue_ready           low while the requested destination is already pending
//   clr_en/clr_rd         completed long-latency writeback releasing a destination
//   rs1, rs2              source registers queried for hazards
//   busy_rs1, busy_rs2    registered pending state of the queried sources
module wb_scoreboard
  import writeback_arbiter_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  issue_valid,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  output logic                  issue_ready,
  input  logic                  clr_en,
  input  logic [REG_ADDR_W-1:0] clr_rd,
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic [REG_ADDR_W-1:0] rs2,
  output logic                  busy_rs1,
  output logic                  busy_rs2
);

  logic [NUM_REGS-1:0] pending;
  logic [NUM_REGS-1:0] pending_d;
  logic [NUM_REGS-1:0] set_mask;
  logic [NUM_REGS-1:0] clr_mask;
  logic                set_en;

  assign issue_ready = !(pending[issue_rd] && (issue_rd != ZERO_REG));
  assign set_en      = issue_valid && issue_ready && (issue_rd != ZERO_REG);

  // Clear is applied before set so a same-cycle reservation survives.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (set_en) set_mask[issue_rd] = 1'b1;
    if (clr_en) clr_mask[clr_rd]   = 1'b1;
    pending_d    = (pending & ~clr_mask) | set_mask;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) pending <= '0;
    else     pending <= pending_d;
  end

  assign busy_rs1 = pending[rs1];
  assign busy_rs2 = pending[rs2];

endmodule

// File: rtl/writeback_arbiter.sv
// Writeback arbiter: merges the single-cycle (alu) and long-latency (lsu)
// result streams onto one register-file write port with round-robin
// arbitration, and tracks outstanding long-latency destinations.
// Optional feature: define WB_BYPASS_EN to add write-port forwarding onto
// the register-file read data (rf_data1/2 -> fwd_data1/2).
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   alu_valid/alu_ready/alu_rd/alu_data   single-cycle result handshake
//   lsu_valid/lsu_ready/lsu_rd/lsu_data   long-latency result handshake
//   issue_valid/issue_ready/issue_rd      long-latency destination reservation
//   rs1, rs2 / busy_rs1, busy_rs2         hazard query
//   wb_rd, wb_data, wb_we                 register-file write port (1-cycle latency)
module writeback_arbiter
  import writeback_arbiter_pkg::*;
#(
  parameter int unsigned N = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [N-1:0]          alu_data,
  input  logic                  lsu_valid,
  output logic                  lsu_ready,
  input  logic [REG_ADDR_W-1:0] lsu_rd,
  input  logic [N-1:0]          lsu_data,
  input  logic                  issue_valid,
  output logic                  issue_ready,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic [REG_ADDR_W-1:0] rs2,
  output logic                  busy_rs1,
  output logic                  busy_rs2,
`ifdef WB_BYPASS_EN
  input  logic [N-1:0]          rf_data1,
  input  logic [N-1:0]          rf_data2,
  output logic [N-1:0]          fwd_data1,
  output logic [N-1:0]          fwd_data2,
`endif
  output logic [REG_ADDR_W-1:0] wb_rd,
  output logic [N-1:0]          wb_data,
  output logic                  wb_we
);

  grant_e prio_q;
  grant_e prio_d;
  logic   alu_fire;
  logic   lsu_fire;

  assign alu_fire = alu_valid && alu_ready;
  assign lsu_fire = lsu_valid && lsu_ready;

  // Priority register.
  always_ff @(posedge clk) begin
    if (rst) prio_q <= GRANT_ALU;
    else     prio_q <= prio_d;
  end

  // Priority passes to the port that did not win the last grant.
  always_comb begin
    prio_d = prio_q;
    if (alu_fire)      prio_d = GRANT_LSU;
    else if (lsu_fire) prio_d = GRANT_ALU;
  end

  // Grant outputs.
  always_comb begin
    alu_ready = alu_valid && (!lsu_valid || (prio_q == GRANT_ALU));
    lsu_ready = lsu_valid && (!alu_valid || (prio_q == GRANT_LSU));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_we   <= 1'b0;
      wb_rd   <= '0;
      wb_data <= '0;
    end else begin
      wb_we <= 1'b0;
      if (alu_fire) begin
        wb_rd   <= alu_rd;
        wb_data <= alu_data;
        wb_we   <= (alu_rd != ZERO_REG);
      end else if (lsu_fire) begin
        wb_rd   <= lsu_rd;
        wb_data <= lsu_data;
        wb_we   <= (lsu_rd != ZERO_REG);
      end
    end
  end

  wb_scoreboard u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .issue_ready (issue_ready),
    .clr_en      (lsu_fire),
    .clr_rd      (lsu_rd),
    .rs1         (rs1),
    .rs2         (rs2),
    .busy_rs1    (busy_rs1),
    .busy_rs2    (busy_rs2)
  );

`ifdef WB_BYPASS_EN
  always_comb begin
    fwd_data1 = rf_data1;
    fwd_data2 = rf_data2;
    if (wb_we && (wb_rd == rs1) && (rs1 != ZERO_REG)) fwd_data1 = wb_data;
    if (wb_we && (wb_rd == rs2) && (rs2 != ZERO_REG)) fwd_data2 = wb_data;
  end
`endif

endmodule

// File: tb/tb_writeback_arbiter.sv
// Randomized scoreboard bench for writeback_arbiter with a behavioural model.
module tb_writeback_arbiter;

  localparam int N = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         alu_valid = 1'b0, lsu_valid = 1'b0, issue_valid = 1'b0;
  logic         alu_ready, lsu_ready, issue_ready, busy_rs1, busy_rs2, wb_we;
  logic [4:0]   alu_rd = '0, lsu_rd = '0, issue_rd = '0, rs1 = '0, rs2 = '0, wb_rd;
  logic [N-1:0] alu_data = '0, lsu_data = '0, wb_data;
`ifdef WB_BYPASS_EN
  logic [N-1:0] rf_data1 = '0, rf_data2 = '0, fwd_data1, fwd_data2;
`endif

  writeback_arbiter #(.N(N)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_rd(issue_rd),
    .rs1(rs1), .rs2(rs2), .busy_rs1(busy_rs1), .busy_rs2(busy_rs2),
`ifdef WB_BYPASS_EN
    .rf_data1(rf_data1), .rf_data2(rf_data2), .fwd_data1(fwd_data1), .fwd_data2(fwd_data2),
`endif
    .wb_rd(wb_rd), .wb_data(wb_data), .wb_we(wb_we)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // Behavioural model: pending set of destinations, last winner, last write.
  typedef struct { int at; logic [4:0] rd; logic [N-1:0] data; } exp_t;
  exp_t       expq[$];
  bit         pend[32];
  int         last_winner = -1;   // -1: none since reset, 0: alu, 1: lsu
  bit         m_we = 0;
  logic [4:0] m_rd = '0;
  logic [N-1:0] m_data = '0;
  bit         armed = 0;

  task automatic model_reset();
    foreach (pend[i]) pend[i] = 0;
    last_winner = -1;
    m_we = 0;
  endtask

  // Write-port monitor: each expected write appears exactly in its cycle.
  always @(negedge clk) begin
    if (armed) begin
      if (expq.size() > 0 && expq[0].at == cyc) begin
        exp_t e;
        e = expq.pop_front();
        chk("wb_we", 64'(wb_we), 64'(1));
        chk("wb_rd", 64'(wb_rd), 64'(e.rd));
        chk("wb_data", 64'(wb_data), 64'(e.data));
      end else begin
        chk("wb_we_idle", 64'(wb_we), 64'(0));
      end
    end
  end

  task automatic step(input logic r,
                      input logic av, input logic [4:0] ard, input logic [N-1:0] adat,
                      input logic lv, input logic [4:0] lrd, input logic [N-1:0] ldat,
                      input logic iv, input logic [4:0] ird,
                      input logic [4:0] s1, input logic [4:0] s2);
    bit a_g, l_g, exp_ir, alu_wins_tie;
    logic [N-1:0] r1, r2;
    @(posedge clk);
    #1;
    rst = r; alu_valid = av; alu_rd = ard; alu_data = adat;
    lsu_valid = lv; lsu_rd = lrd; lsu_data = ldat;
    issue_valid = iv; issue_rd = ird; rs1 = s1; rs2 = s2;
    r1 = N'($urandom); r2 = N'($urandom);
`ifdef WB_BYPASS_EN
    rf_data1 = r1; rf_data2 = r2;
`endif
    @(negedge clk);
    alu_wins_tie = (last_winner != 0);
    a_g = av && (!lv || alu_wins_tie);
    l_g = lv && (!av || !alu_wins_tie);
    exp_ir = (ird == 0) || !pend[ird];
    chk("alu_ready", 64'(alu_ready), 64'(a_g));
    chk("lsu_ready", 64'(lsu_ready), 64'(l_g));
    chk("issue_ready", 64'(issue_ready), 64'(exp_ir));
    chk("busy_rs1", 64'(busy_rs1), 64'(pend[s1]));
    chk("busy_rs2", 64'(busy_rs2), 64'(pend[s2]));
`ifdef WB_BYPASS_EN
    chk("fwd_data1", 64'(fwd_data1), 64'((m_we && m_rd == s1 && s1 != 0) ? m_data : r1));
    chk("fwd_data2", 64'(fwd_data2), 64'((m_we && m_rd == s2 && s2 != 0) ? m_data : r2));
`endif
    if (r) begin
      model_reset();
    end else begin
      m_we = 0;
      if (a_g) begin
        last_winner = 0;
        m_we = (ard != 0); m_rd = ard; m_data = adat;
      end else if (l_g) begin
        last_winner = 1;
        m_we = (lrd != 0); m_rd = lrd; m_data = ldat;
        pend[lrd] = 0;
      end
      if (iv && exp_ir && ird != 0) pend[ird] = 1;
      pend[0] = 0;
      if (m_we) expq.push_back('{at: cyc + 1, rd: m_rd, data: m_data});
    end
  endtask

  task automatic idle(input logic [4:0] s1, input logic [4:0] s2);
    step(0, 0, 0, '0, 0, 0, '0, 0, 0, s1, s2);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_wb_we", 64'(wb_we), 64'(0));
    chk("reset_wb_rd", 64'(wb_rd), 64'(0));
    chk("reset_wb_data", 64'(wb_data), 64'(0));
    armed = 1;
    // single alu result
    step(0, 1, 5, 32'hDEADBEEF, 0, 0, '0, 0, 0, 0, 0);
    idle(0, 0); idle(0, 0);
    // contention after reset: alu, lsu, alu, lsu
    step(1, 0, 0, '0, 0, 0, '0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 1, N'(32'h100 + i), 1, 2, N'(32'h200 + i), 0, 0, 0, 0);
    idle(0, 0);
    // reserve 7, re-issue blocked, release by lsu
    step(0, 0, 0, '0, 0, 0, '0, 1, 7, 7, 0);
    step(0, 0, 0, '0, 0, 0, '0, 1, 7, 7, 7);
    step(0, 0, 0, '0, 1, 7, 32'h77, 0, 0, 7, 0);
    idle(7, 0);
    // same-cycle clear and set of 9, then issue to rd 0
    step(0, 0, 0, '0, 1, 9, 32'h99, 1, 9, 9, 0);
    step(0, 0, 0, '0, 0, 0, '0, 1, 0, 9, 0);
    idle(0, 9);
    // rd 0 result, then forwarding of rd 3
    step(0, 1, 0, 32'h1234, 0, 0, '0, 0, 0, 0, 0);
    step(0, 1, 3, 32'h3333, 0, 0, '0, 0, 0, 0, 3);
    idle(0, 3);
    // reset mid-stream with pending bits and a grant in flight
    step(0, 1, 4, 32'h44, 1, 5, 32'h55, 1, 6, 6, 9);
    step(1, 1, 4, 32'h45, 1, 5, 32'h56, 1, 8, 6, 9);
    step(0, 1, 10, 32'hA, 1, 11, 32'hB, 0, 0, 6, 9);
    idle(0, 0);
    // randomized traffic over a small register window to provoke hazards
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 99) == 0),
           1'($urandom), 5'($urandom_range(0, 7)), N'($urandom),
           1'($urandom), 5'($urandom_range(0, 7)), N'($urandom),
           1'($urandom), 5'($urandom_range(0, 7)),
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end
    idle(0, 0); idle(0, 0);
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL drain leftover=%0d expected=0", expq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/writeback_arbiter.md
WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

Interface
REQ-001 Parameter: N, default 32, data width of every result and write-data path.
REQ-002 Port: clk  input  1  sole clock; every flop updates on the rising edge.
REQ-003 Port: rst  input  1  synchronous, active-high reset.
REQ-004 Port: alu_valid / alu_ready  input / output  1 / 1  handshake for the single-cycle result.
REQ-005 Port: alu_rd, alu_data  input  5 / N  destination register and result for the single-cycle result.
REQ-006 Port: lsu_valid / lsu_ready  input / output  1 / 1  handshake for the long-latency (load/mul/div) result.
REQ-007 Port: lsu_rd, lsu_data  input  5 / N  destination register and result for the long-latency result.
REQ-008 Port: issue_valid / issue_ready  input / output  1 / 1  handshake that reserves a long-latency destination.
REQ-009 Port: issue_rd  input  5  destination register being reserved.
REQ-010 Port: rs1, rs2  input  5 / 5  source registers queried for hazards.
REQ-011 Port: busy_rs1, busy_rs2  output  1 / 1  the queried register has a pending long-latency write.
REQ-012 Port: wb_rd, wb_data, wb_we  output  5 / N / 1  register-file write port.

Function
REQ-013 A handshake SHALL complete only in a cycle where both valid and ready are high.
REQ-014 alu_ready and lsu_ready SHALL be combinational; at most one of them SHALL be high in a cycle where both valid inputs are high.
REQ-015 One valid input alone SHALL be granted, with its ready high.
REQ-016 Both valid inputs SHALL be arbitrated round-robin; the port not granted last time wins, and ties after reset go to alu.
REQ-017 The granted result SHALL appear on wb_rd / wb_data the next cycle, with wb_we=1 for exactly one cycle (1-cycle latency).
REQ-018 wb_we SHALL be 0 for a result whose rd is 0, although the handshake still completes.
REQ-019 The scoreboard SHALL hold 32 pending bits; bit 0 SHALL always read 0.
REQ-020 issue_ready SHALL be low when pending[issue_rd]=1 and issue_rd!=0; otherwise it SHALL be high.
REQ-021 A completed issue with issue_rd!=0 SHALL set pending[issue_rd] at the next edge; an issue to rd 0 SHALL change no bit.
REQ-022 A completed lsu handshake SHALL clear pending[lsu_rd] at the next edge.
REQ-023 When a set and a clear hit the same bit in the same cycle, the set SHALL win.
REQ-024 busy_rsX SHALL equal pending[rsX] combinationally and SHALL ignore same-cycle set or clear.
REQ-025 An lsu result whose destination is not pending SHALL still be written back; this is not an error.

Reset
REQ-026 While rst=1 at an edge: wb_we<=0, wb_rd<=0, wb_data<=0, all pending bits<=0, and the round-robin pointer points to alu.
REQ-027 A handshake in a cycle where rst=1 SHALL be discarded, producing no write and no scoreboard change.
REQ-028 The first edge after rst falls SHALL behave as the first edge after reset.

Configuration
REQ-029 Macro WB_BYPASS_EN: when defined, the block SHALL add inputs rf_data1 / rf_data2 (N bits each) and outputs fwd_data1 / fwd_data2 (N bits each).
REQ-030 With WB_BYPASS_EN defined, fwd_dataX SHALL equal wb_data when wb_we=1, wb_rd==rsX and rsX!=0; otherwise it SHALL equal rf_dataX.
REQ-031 Without WB_BYPASS_EN, those ports SHALL be absent and all other behaviour SHALL be unchanged.

Structure
REQ-032 A shared package SHALL hold REG_ADDR_W=5, NUM_REGS=32, ZERO_REG=0 and the grant encoding (GRANT_ALU=0, GRANT_LSU=1).
REQ-033 The block SHALL instantiate exactly one sub-module, wb_scoreboard: the 32-bit pending vector, set/clear logic and the busy/issue_ready lookups.

Verification
REQ-034 Scenario: alu_valid=1, rd=5, data=0xDEADBEEF, lsu idle -> alu_ready=1, then next cycle wb_we=1, wb_rd=5, wb_data=0xDEADBEEF, then wb_we=0.
REQ-035 Scenario: both valid for 4 cycles (alu rd=1, lsu rd=2), starting after reset -> grants alu, lsu, alu, lsu; writes to rd 1, 2, 1, 2 appear one cycle later.
REQ-036 Scenario: issue rd=7, then query rs1=7 -> busy_rs1=1 and a second issue to rd=7 has issue_ready=0; lsu result rd=7 -> busy_rs1=0 from the next cycle.
REQ-037 Scenario: lsu clear of rd=9 and issue of rd=9 in the same cycle -> pending[9]=1 afterwards; issue rd=0 -> issue_ready=1 and busy for rs=0 stays 0.
REQ-038 Scenario: alu result rd=0, data=0x1234 -> alu_ready=1 and wb_we stays 0; with WB_BYPASS_EN, wb write rd=3, rs2=3 -> fwd_data2=wb_data.
REQ-039 Scenario: rst=1 asserted for one cycle mid-stream with pending bits set and a grant in flight -> next cycle wb_we=0, all busy=0, and the next tie grants alu.
